// File: rtl/vscale_htif_pcr_master_pkg.sv
// vscale_htif_pcr_master_pkg: shared widths, TO_HOST address, FSM and source encodings
// for the HTIF PCR host-side master.
package vscale_htif_pcr_master_pkg;
   localparam int CSR_ADDR_WIDTH = 12;
   localparam int HTIF_PCR_WIDTH = 64;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RESP,
      ST_HOST_RESP,
      ST_TOHOST_OUT
   } state_t;
   typedef enum logic {
      SRC_HOST,
      SRC_POLL
   } src_t;
endpackage

// File: rtl/vscale_htif_poll_timer.sv
// vscale_htif_poll_timer: reload down-counter that raises a sticky pending flag
// once every INTERVAL enabled cycles; clear consumes the flag.
module vscale_htif_poll_timer #(
   parameter int INTERVAL = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic pending
);
   localparam int CW = $clog2(INTERVAL);
   logic [CW-1:0] cnt;
   logic hit;
   assign hit = enable && (cnt == '0);
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= CW'(INTERVAL - 1);
         pending <= 1'b0;
      end else begin
         cnt     <= hit ? CW'(INTERVAL - 1) : (enable ? cnt - 1'b1 : cnt);
         pending <= hit | (pending & ~clear);
      end
   end
endmodule

// File: rtl/vscale_htif_pcr_master.sv
// vscale_htif_pcr_master: bridges host CSR commands onto htif_pcr_req/resp and,
// when VSCALE_HTIF_POLL_EN is defined, polls TO_HOST and forwards nonzero values.
module vscale_htif_pcr_master
   import vscale_htif_pcr_master_pkg::*;
#(
   parameter int ADDR_WIDTH = CSR_ADDR_WIDTH,
   parameter int DATA_WIDTH = HTIF_PCR_WIDTH,
   parameter int POLL_INTERVAL = 256,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = CSR_ADDR_TO_HOST
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  poll_enable,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  tohost_valid,
   input  logic                  tohost_ready,
   output logic [DATA_WIDTH-1:0] tohost_data,
   output logic                  htif_pcr_req_valid,
   input  logic                  htif_pcr_req_ready,
   output logic                  htif_pcr_req_rw,
   output logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
   output logic [DATA_WIDTH-1:0] htif_pcr_req_data,
   input  logic                  htif_pcr_resp_valid,
   output logic                  htif_pcr_resp_ready,
   input  logic [DATA_WIDTH-1:0] htif_pcr_resp_data
);
   state_t state, state_n;
   logic rw_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic take_cmd;
   assign take_cmd = (state == ST_IDLE) && cmd_valid;
`ifdef VSCALE_HTIF_POLL_EN
   src_t src_q;
   logic poll_pending, poll_take;
   assign poll_take = (state == ST_IDLE) && !cmd_valid && poll_pending;
   vscale_htif_poll_timer #(.INTERVAL(POLL_INTERVAL)) u_poll_timer (
      .clk(clk),
      .reset(reset),
      .enable(poll_enable),
      .clear(poll_take),
      .pending(poll_pending)
   );
   assign tohost_valid = (state == ST_TOHOST_OUT);
   assign tohost_data  = rdata_q;
`else
   logic unused_ok;
   assign unused_ok    = ^{poll_enable, tohost_ready, TOHOST_ADDR, POLL_INTERVAL[0]};
   assign tohost_valid = 1'b0;
   assign tohost_data  = '0;
`endif
   // cmd_ready is gated by reset so nothing is accepted while the block is held in reset
   assign cmd_ready           = reset && (state == ST_IDLE);
   assign htif_pcr_req_valid  = (state == ST_REQ);
   assign htif_pcr_req_rw     = rw_q;
   assign htif_pcr_req_addr   = addr_q;
   assign htif_pcr_req_data   = wdata_q;
   assign htif_pcr_resp_ready = (state == ST_WAIT_RESP);
   assign resp_valid          = (state == ST_HOST_RESP);
   assign resp_data           = rdata_q;
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: begin
`ifdef VSCALE_HTIF_POLL_EN
            if (cmd_valid || poll_pending) state_n = ST_REQ;
`else
            if (cmd_valid) state_n = ST_REQ;
`endif
         end
         ST_REQ:       if (htif_pcr_req_ready) state_n = ST_WAIT_RESP;
         ST_WAIT_RESP: begin
`ifdef VSCALE_HTIF_POLL_EN
            if (htif_pcr_resp_valid)
               state_n = (src_q == SRC_HOST) ? ST_HOST_RESP :
                         (htif_pcr_resp_data != '0) ? ST_TOHOST_OUT : ST_IDLE;
`else
            if (htif_pcr_resp_valid) state_n = ST_HOST_RESP;
`endif
         end
         ST_HOST_RESP: if (resp_ready) state_n = ST_IDLE;
`ifdef VSCALE_HTIF_POLL_EN
         ST_TOHOST_OUT: if (tohost_ready) state_n = ST_IDLE;
`endif
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef VSCALE_HTIF_POLL_EN
         src_q   <= SRC_HOST;
`endif
      end else begin
         state <= state_n;
         if (take_cmd) begin
            rw_q    <= cmd_rw;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_data;
         end
`ifdef VSCALE_HTIF_POLL_EN
         else if (poll_take) begin
            rw_q    <= 1'b0;
            addr_q  <= TOHOST_ADDR;
            wdata_q <= '0;
         end
         if (state == ST_IDLE) src_q <= cmd_valid ? SRC_HOST : SRC_POLL;
`endif
         if ((state == ST_WAIT_RESP) && htif_pcr_resp_valid) rdata_q <= htif_pcr_resp_data;
      end
   end
endmodule

// File: tb/tb_vscale_htif_pcr_master.sv
// tb_vscale_htif_pcr_master: scoreboard bench with a CSR-file responder model;
// poll scenarios run when VSCALE_HTIF_POLL_EN is defined.
module tb_vscale_htif_pcr_master;
   logic clk = 0, reset = 0, poll_enable = 0;
   logic cmd_valid = 0, cmd_ready, cmd_rw = 0;
   logic [11:0] cmd_addr = '0;
   logic [63:0] cmd_data = '0;
   logic resp_valid, resp_ready = 1;
   logic [63:0] resp_data;
   logic tohost_valid, tohost_ready = 1;
   logic [63:0] tohost_data;
   logic htif_pcr_req_valid, htif_pcr_req_ready = 1, htif_pcr_req_rw;
   logic [11:0] htif_pcr_req_addr;
   logic [63:0] htif_pcr_req_data;
   logic htif_pcr_resp_valid = 0, htif_pcr_resp_ready;
   logic [63:0] htif_pcr_resp_data = '0;

   typedef struct packed {logic rw; logic [11:0] addr; logic [63:0] data;} req_t;
   req_t exp_req[$];
   logic [63:0] exp_resp[$], exp_tohost[$];
   int passed = 0, total = 0, cyc = 0, req_cnt = 0, last_poll = 0;
   logic [63:0] csr [0:4095];
   logic resp_due = 0, resp_hold = 0;
   logic [63:0] due_data = '0;
   localparam req_t POLL_REQ = {1'b0, 12'h780, 64'h0};

   vscale_htif_pcr_master dut (
      .clk(clk), .reset(reset), .poll_enable(poll_enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
      .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
      .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
      .htif_pcr_req_data(htif_pcr_req_data),
      .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
      .htif_pcr_resp_data(htif_pcr_resp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Responder: answers one cycle after the request handshake unless held, clears TO_HOST on read
   initial begin
      for (int i = 0; i < 4096; i++) csr[i] = '0;
      forever begin
         @(negedge clk); #1;
         if (!reset) begin
            resp_due = 0;
            htif_pcr_resp_valid = 0;
         end else begin
            if (htif_pcr_resp_valid && !htif_pcr_resp_ready) htif_pcr_resp_valid = 0;
            if (resp_due && !resp_hold) begin
               htif_pcr_resp_valid = 1;
               htif_pcr_resp_data = due_data;
               resp_due = 0;
            end
            if (htif_pcr_req_valid && htif_pcr_req_ready) begin
               due_data = csr[htif_pcr_req_addr];
               resp_due = 1;
               if (htif_pcr_req_rw) csr[htif_pcr_req_addr] = htif_pcr_req_data;
               else if (htif_pcr_req_addr == 12'h780) csr[htif_pcr_req_addr] = '0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake the DUT takes part in
   initial begin
      req_t e;
      logic [63:0] v;
      forever begin
         @(negedge clk); #2;
         if (htif_pcr_req_valid && htif_pcr_req_ready) begin
            req_cnt++;
            if (!htif_pcr_req_rw && htif_pcr_req_addr == 12'h780) last_poll = cyc;
            if (exp_req.size() == 0) chk("req_unexpected", 64'(exp_req.size()), 1);
            else begin
               e = exp_req.pop_front();
               chk("req_rw", 64'(htif_pcr_req_rw), 64'(e.rw));
               chk("req_addr", 64'(htif_pcr_req_addr), 64'(e.addr));
               chk("req_data", htif_pcr_req_data, e.data);
            end
         end
         if (resp_valid && resp_ready) begin
            if (exp_resp.size() == 0) chk("resp_unexpected", 64'(exp_resp.size()), 1);
            else begin
               v = exp_resp.pop_front();
               chk("resp_data", resp_data, v);
            end
         end
         if (tohost_valid && tohost_ready) begin
            if (exp_tohost.size() == 0) chk("tohost_unexpected", 64'(exp_tohost.size()), 1);
            else begin
               v = exp_tohost.pop_front();
               chk("tohost_data", tohost_data, v);
            end
         end
      end
   end

   task automatic issue(input logic rw, input logic [11:0] a, input logic [63:0] d, input logic [63:0] r);
      exp_req.push_back({rw, a, d});
      exp_resp.push_back(r);
      cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_accept", 64'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_resp.size() != 0; i++) @(negedge clk);
      chk("resp_drained", 64'(exp_resp.size()), 0);
   endtask

   task automatic wait_poll();
      int n = last_poll;
      for (int i = 0; i < 400 && last_poll == n; i++) @(negedge clk);
      chk("poll_arrived", 64'(last_poll != n), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p, n, r0;
      logic seen;
      cmd_valid = 1; cmd_addr = 12'h781;
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", 64'({cmd_ready, resp_valid, tohost_valid, htif_pcr_req_valid, htif_pcr_resp_ready}), 0);
      end
      cmd_valid = 0; reset = 1;
      @(negedge clk);
      chk("cmd_ready_after_reset", 64'(cmd_ready), 1);

      resp_ready = 0;
      exp_req.push_back({1'b1, 12'h781, 64'h5});
      exp_resp.push_back(64'h0);
      cmd_rw = 1; cmd_addr = 12'h781; cmd_data = 64'h5; cmd_valid = 1;
      chk("cmd_ready_idle", 64'(cmd_ready), 1);
      @(negedge clk); cmd_valid = 0;
      chk("latency_req_n1", 64'(htif_pcr_req_valid), 1);
      @(negedge clk);
      chk("req_one_cycle", 64'(htif_pcr_req_valid), 0);
      @(negedge clk);
      chk("latency_resp_n3", 64'(resp_valid), 1);
      repeat (4) begin
         @(negedge clk);
         chk("resp_hold_valid", 64'(resp_valid), 1);
         chk("resp_hold_data", resp_data, 64'h0);
      end
      resp_ready = 1;
      @(negedge clk);
      chk("resp_released", 64'(resp_valid), 0);

      issue(1, 12'h300, 64'hdead_beef_0000_0001, 64'h0);
      issue(0, 12'h300, 64'h0, 64'hdead_beef_0000_0001);
      issue(1, 12'h300, 64'h55, 64'hdead_beef_0000_0001);
      issue(0, 12'h781, 64'h0, 64'h5);
      drain();

      htif_pcr_req_ready = 0;
      issue(0, 12'h300, 64'h0, 64'h55);
      repeat (3) begin
         chk("req_stall_valid", 64'(htif_pcr_req_valid), 1);
         chk("req_stall_addr", 64'(htif_pcr_req_addr), 64'h300);
         @(negedge clk);
      end
      htif_pcr_req_ready = 1;
      drain();

      resp_hold = 1;
      issue(0, 12'h300, 64'h0, 64'h55);
      for (int i = 0; i < 20 && !htif_pcr_resp_ready; i++) @(negedge clk);
      chk("reached_wait_resp", 64'(htif_pcr_resp_ready), 1);
      reset = 0; poll_enable = 1;
      void'(exp_resp.pop_back());
      @(negedge clk);
      chk("midreset_outputs", 64'({cmd_ready, resp_valid, tohost_valid, htif_pcr_req_valid, htif_pcr_resp_ready}), 0);
      reset = 1; resp_hold = 0; tohost_ready = 1; r0 = cyc;
      @(negedge clk);
      chk("idle_after_reset", 64'(cmd_ready), 1);

`ifdef VSCALE_HTIF_POLL_EN
      exp_req.push_back(POLL_REQ);
      wait_poll();
      chk("poll_after_reload", 64'(last_poll - r0), 257);
      p = last_poll;
      repeat (2) begin
         exp_req.push_back(POLL_REQ);
         wait_poll();
         chk("poll_interval", 64'(last_poll - p), 256);
         p = last_poll;
      end
      csr[12'h780] = 64'h1; tohost_ready = 0;
      exp_req.push_back(POLL_REQ);
      exp_tohost.push_back(64'h1);
      for (int i = 0; i < 400 && !tohost_valid; i++) @(negedge clk);
      chk("tohost_seen", 64'(tohost_valid), 1);
      n = req_cnt;
      repeat (10) begin
         @(negedge clk);
         chk("tohost_hold_valid", 64'(tohost_valid), 1);
         chk("tohost_hold_data", tohost_data, 64'h1);
      end
      chk("no_req_while_blocked", 64'(req_cnt), 64'(n));
      tohost_ready = 1;
      @(negedge clk); @(negedge clk);
      chk("tohost_cleared", 64'(tohost_valid), 0);
      chk("tohost_consumed", 64'(exp_tohost.size()), 0);
      p = last_poll;
      for (int i = 0; i < 400 && cyc < p + 255; i++) @(negedge clk);
      chk("conflict_cycle", 64'(cyc), 64'(p + 255));
      issue(0, 12'h781, 64'h0, 64'h5);
      exp_req.push_back(POLL_REQ);
      wait_poll();
      chk("poll_after_host", 64'(last_poll), 64'(p + 260));
      poll_enable = 0;
      drain();
      repeat (300) @(negedge clk);
`else
      n = req_cnt; seen = 0;
      repeat (600) begin
         @(negedge clk);
         seen = seen | tohost_valid;
      end
      chk("no_poll_req", 64'(req_cnt), 64'(n));
      chk("tohost_never", 64'(seen), 0);
      issue(0, 12'h781, 64'h0, 64'h5);
      drain();
`endif
      repeat (5) @(negedge clk);
      chk("req_queue_empty", 64'(exp_req.size()), 0);
      chk("resp_queue_empty", 64'(exp_resp.size()), 0);
      chk("tohost_queue_empty", 64'(exp_tohost.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
